// File: rtl/pcx_rptr_pipe.sv
// pcx_rptr_pipe -- PCX repeater stage.
// Carries the SPC->PCX request/atom vectors, PCX->SPC grants and scache->PCX
// stalls across the die through DEPTH retiming flops. Each path has its own
// configurable output polarity. A per-channel monitor tracks outstanding
// requests per destination and raises sticky protocol-error flags.
// Ports:
//   rclk, rst_l      clock, synchronous active-low reset
//   req_in/atom_in   SPC request (bit c*NDST+d) and per-channel atomic marker
//   grant_in         arbiter grant, same layout as req_in
//   stall_in         per-destination stall
//   req_out, atom_out, grant_out, stall_out   retimed copies, polarity per *_INV
//   ovf_err/unf_err/atom_err   sticky per-channel error flags

// Per-channel outstanding-request monitor: one 2-bit counter per destination.
module pcx_rptr_mon #(
  parameter int NDST      = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [NDST-1:0]      req,
  input  logic [NDST-1:0]      grant,
  input  logic                 atom,
  output logic [NDST-1:0][1:0] cnt,
  output logic                 ovf_err,
  output logic                 unf_err,
  output logic                 atom_err
);
  localparam logic [1:0] MAX = 2'(MAX_OUTST);

  logic [NDST-1:0]      ovf_hit, unf_hit;
  logic [NDST-1:0][1:0] cnt_nxt;

  // req+grant together cancel, so neither error can fire in that case.
  always_comb begin
    ovf_hit = '0;
    unf_hit = '0;
    cnt_nxt = cnt;
    for (int d = 0; d < NDST; d++) begin
      if (req[d] && !grant[d]) begin
        if (cnt[d] == MAX) ovf_hit[d] = 1'b1;
        else               cnt_nxt[d] = cnt[d] + 2'd1;
      end else if (grant[d] && !req[d]) begin
        if (cnt[d] == 2'd0) unf_hit[d] = 1'b1;
        else                cnt_nxt[d] = cnt[d] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt      <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      atom_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ovf_err  <= ovf_err  | (|ovf_hit);
      unf_err  <= unf_err  | (|unf_hit);
      atom_err <= atom_err | (atom & ~(|req));
    end
  end
endmodule

module pcx_rptr_pipe #(
  parameter int NCH         = 5,
  parameter int NDST        = 5,
  parameter int DEPTH       = 1,
  parameter bit REQ_OUT_INV = 1'b0,
  parameter bit GNT_OUT_INV = 1'b1,
  parameter bit STL_OUT_INV = 1'b0,
  parameter int MAX_OUTST   = 2
) (
  input  logic                rclk,
  input  logic                rst_l,
  input  logic [NCH*NDST-1:0] req_in,
  input  logic [NCH-1:0]      atom_in,
  input  logic [NCH*NDST-1:0] grant_in,
  input  logic [NDST-1:0]     stall_in,
  output logic [NCH*NDST-1:0] req_out,
  output logic [NCH-1:0]      atom_out,
  output logic [NCH*NDST-1:0] grant_out,
  output logic [NDST-1:0]     stall_out,
  output logic [NCH-1:0]      ovf_err,
  output logic [NCH-1:0]      unf_err,
  output logic [NCH-1:0]      atom_err
);
  generate
    if (DEPTH < 0 || DEPTH > 3) begin : g_bad_depth
      $error("pcx_rptr_pipe: DEPTH must be 0..3");
    end
    if (MAX_OUTST < 1 || MAX_OUTST > 3) begin : g_bad_max
      $error("pcx_rptr_pipe: MAX_OUTST must be 1..3");
    end
  endgenerate

  // All paths share one shift register; req and atom sit in the same word,
  // so they can never drift apart. Flops hold logical (active-high) values,
  // inversion is applied only at the output.
  localparam int W = 2*NCH*NDST + NCH + NDST;
  localparam logic [W-1:0] INV_MASK = {{(NCH*NDST){REQ_OUT_INV}}, {NCH{REQ_OUT_INV}},
                                       {(NCH*NDST){GNT_OUT_INV}}, {NDST{STL_OUT_INV}}};

  logic [W-1:0] bus_in, bus_out;
  assign bus_in = {req_in, atom_in, grant_in, stall_in};

  generate
    if (DEPTH == 0) begin : g_comb
      assign bus_out = bus_in;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] stg;
      always_ff @(posedge rclk) begin
        if (!rst_l) stg <= '0;
        else begin
          stg[0] <= bus_in;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end
      assign bus_out = stg[DEPTH-1];
    end
  endgenerate

  assign {req_out, atom_out, grant_out, stall_out} = bus_out ^ INV_MASK;

  // Counters run off the un-retimed inputs.
  logic [NCH-1:0][NDST-1:0][1:0] cnt;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pcx_rptr_mon #(.NDST(NDST), .MAX_OUTST(MAX_OUTST)) u_mon (
      .clk      (rclk),
      .rst_l    (rst_l),
      .req      (req_in[c*NDST +: NDST]),
      .grant    (grant_in[c*NDST +: NDST]),
      .atom     (atom_in[c]),
      .cnt      (cnt[c]),
      .ovf_err  (ovf_err[c]),
      .unf_err  (unf_err[c]),
      .atom_err (atom_err[c])
    );
  end
endmodule

// File: tb/tb_pcx_rptr_pipe.sv
// Directed bench for pcx_rptr_pipe: four instances (DEPTH 0/1/2/3, mixed
// polarities) share one stimulus; a delay-line history and a counter model
// give the expected outputs each cycle, plus hand-computed spot checks.
module tb_pcx_rptr_pipe;
  localparam int NCH = 5, NDST = 5, N = NCH*NDST, BW = 2*N + NCH + NDST;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [N-1:0]  req_in, grant_in;
  logic [NCH-1:0] atom_in;
  logic [NDST-1:0] stall_in;

  logic [N-1:0]    ro [4], go [4];
  logic [NCH-1:0]  ao [4], oe [4], ue [4], ae [4];
  logic [NDST-1:0] so [4];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pcx_rptr_pipe #(.DEPTH(0), .REQ_OUT_INV(1'b1), .GNT_OUT_INV(1'b0), .STL_OUT_INV(1'b1)) u0 (
    .rclk(clk), .rst_l(rst_l), .req_in(req_in), .atom_in(atom_in), .grant_in(grant_in),
    .stall_in(stall_in), .req_out(ro[0]), .atom_out(ao[0]), .grant_out(go[0]),
    .stall_out(so[0]), .ovf_err(oe[0]), .unf_err(ue[0]), .atom_err(ae[0]));
  pcx_rptr_pipe u1 (
    .rclk(clk), .rst_l(rst_l), .req_in(req_in), .atom_in(atom_in), .grant_in(grant_in),
    .stall_in(stall_in), .req_out(ro[1]), .atom_out(ao[1]), .grant_out(go[1]),
    .stall_out(so[1]), .ovf_err(oe[1]), .unf_err(ue[1]), .atom_err(ae[1]));
  pcx_rptr_pipe #(.DEPTH(2), .GNT_OUT_INV(1'b1)) u2 (
    .rclk(clk), .rst_l(rst_l), .req_in(req_in), .atom_in(atom_in), .grant_in(grant_in),
    .stall_in(stall_in), .req_out(ro[2]), .atom_out(ao[2]), .grant_out(go[2]),
    .stall_out(so[2]), .ovf_err(oe[2]), .unf_err(ue[2]), .atom_err(ae[2]));
  pcx_rptr_pipe #(.DEPTH(3), .REQ_OUT_INV(1'b1), .GNT_OUT_INV(1'b1), .STL_OUT_INV(1'b1)) u3 (
    .rclk(clk), .rst_l(rst_l), .req_in(req_in), .atom_in(atom_in), .grant_in(grant_in),
    .stall_in(stall_in), .req_out(ro[3]), .atom_out(ao[3]), .grant_out(go[3]),
    .stall_out(so[3]), .ovf_err(oe[3]), .unf_err(ue[3]), .atom_err(ae[3]));

  // ---------------- reference model ----------------
  logic [BW-1:0]    hist [3];
  logic [N-1:0][1:0] mc;
  logic [NCH-1:0]   mo, mu, ma;

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    mc = '0; mo = '0; mu = '0; ma = '0;
  end

  always @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      mc <= '0; mo <= '0; mu <= '0; ma <= '0;
    end else begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= {req_in, atom_in, grant_in, stall_in};
      for (int k = 0; k < N; k++) begin
        if (req_in[k] && !grant_in[k]) begin
          if (mc[k] == 2'd2) mo[k/NDST] <= 1'b1;
          else               mc[k] <= mc[k] + 2'd1;
        end else if (grant_in[k] && !req_in[k]) begin
          if (mc[k] == 2'd0) mu[k/NDST] <= 1'b1;
          else               mc[k] <= mc[k] - 2'd1;
        end
      end
      for (int c = 0; c < NCH; c++)
        if (atom_in[c] && req_in[c*NDST +: NDST] == '0) ma[c] <= 1'b1;
    end
  end

  function automatic logic [BW-1:0] exp_raw(input int d);
    if (d == 0) return {req_in, atom_in, grant_in, stall_in};
    return hist[d-1];
  endfunction

  function automatic logic [BW-1:0] mask(input bit r, input bit g, input bit s);
    return {{N{r}}, {NCH{r}}, {N{g}}, {NDST{s}}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check every instance against the model at the falling edge, then advance.
  task automatic step();
    @(negedge clk);
    chk("pipe_d0", 64'({ro[0], ao[0], go[0], so[0]}), 64'(exp_raw(0) ^ mask(1, 0, 1)));
    chk("pipe_d1", 64'({ro[1], ao[1], go[1], so[1]}), 64'(exp_raw(1) ^ mask(0, 1, 0)));
    chk("pipe_d2", 64'({ro[2], ao[2], go[2], so[2]}), 64'(exp_raw(2) ^ mask(0, 1, 0)));
    chk("pipe_d3", 64'({ro[3], ao[3], go[3], so[3]}), 64'(exp_raw(3) ^ mask(1, 1, 1)));
    chk("cnt", 64'(u1.cnt), 64'(mc));
    chk("ovf", 64'(oe[1]), 64'(mo));
    chk("unf", 64'(ue[1]), 64'(mu));
    chk("atom", 64'(ae[1]), 64'(ma));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
  endtask

  initial begin
    rst_l = 1'b0; req_in = '0; grant_in = '0; atom_in = '0; stall_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_l = 1'b1;

    // reset state
    chk("rst_req1", 64'(ro[1]), 64'd0);
    chk("rst_gnt1", 64'(go[1]), {39'd0, {25{1'b1}}});
    chk("rst_req3", 64'(ro[3]), {39'd0, {25{1'b1}}});
    chk("rst_cnt", 64'(u1.cnt), 64'd0);
    chk("rst_err", 64'({oe[1], ue[1], ae[1]}), 64'd0);

    // 1: reset flush on DEPTH=2 inverted grant path
    grant_in = '1;
    repeat (4) step();
    rst_l = 1'b0;
    step();
    chk("flush_g2", 64'(go[2]), {39'd0, {25{1'b1}}});
    chk("flush_unf", 64'(ue[1]), 64'd0);
    rst_l = 1'b1;
    step();
    chk("lat1_g2", 64'(go[2]), {39'd0, {25{1'b1}}});
    step();
    chk("lat2_g2", 64'(go[2]), 64'd0);
    grant_in = '0;
    do_reset();

    // 2: walking one on req with aligned atom
    for (int k = 0; k < N; k++) begin
      req_in  = N'(1) << k;
      atom_in = NCH'(1) << (k / NDST);
      stall_in = NDST'(k);
      step();
      if (k == 7) begin
        chk("walk_r1", 64'(ro[1]), 64'h80);
        chk("walk_a1", 64'(ao[1]), 64'h02);
      end
    end
    req_in = '0; atom_in = '0; stall_in = '0;
    repeat (3) step();
    do_reset();

    // 3: overflow on (c=1,d=2)
    req_in = N'(1) << 7;
    step(); step();
    chk("ovf_cnt2", 64'(u1.cnt[1][2]), 64'd2);
    chk("ovf_pre", 64'(oe[1]), 64'd0);
    step();
    chk("ovf_set", 64'(oe[1]), 64'b00010);
    chk("ovf_hold", 64'(u1.cnt[1][2]), 64'd2);
    req_in = '0;
    do_reset();

    // 4: simultaneous req+grant at the limit
    req_in = N'(1);
    step(); step();
    grant_in = N'(1);
    repeat (5) step();
    chk("sim_cnt", 64'(u1.cnt[0][0]), 64'd2);
    chk("sim_err", 64'({oe[1], ue[1]}), 64'd0);
    req_in = '0;
    step(); step();
    chk("sim_drain", 64'(u1.cnt[0][0]), 64'd0);
    grant_in = '0;
    do_reset();

    // 5: underflow and atom error, sticky until reset
    grant_in = N'(1) << 24;
    step();
    grant_in = '0;
    chk("unf_set", 64'(ue[1]), 64'b10000);
    atom_in = 5'b01000;
    step();
    atom_in = '0;
    chk("atom_set", 64'(ae[1]), 64'b01000);
    repeat (3) step();
    chk("sticky", 64'({ue[1], ae[1]}), 64'({5'b10000, 5'b01000}));
    do_reset();
    chk("err_clr", 64'({oe[1], ue[1], ae[1]}), 64'd0);

    // 6: legal random soak
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < N; k++) begin
        req_in[k]   = ($urandom_range(0, 2) == 0) && (mc[k] < 2'd2);
        grant_in[k] = ($urandom_range(0, 2) == 0) && (mc[k] > 2'd0);
      end
      for (int c = 0; c < NCH; c++)
        atom_in[c] = ($urandom_range(0, 1) == 1) && (req_in[c*NDST +: NDST] != '0);
      stall_in = NDST'($urandom);
      step();
    end
    chk("soak_err", 64'({oe[1], ue[1], ae[1]}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
